// File: rtl/pc_fetch_ctrl.sv
// Front-end program counter: picks the next fetch address from trap, redirect,
// return-address stack or sequential step, and offers it to instruction memory.
module pc_fetch_ctrl #(
  parameter int                WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_ADDR  = 32'h0000_0000,
  parameter logic [WIDTH-1:0]  TRAP_VECTOR = 32'h0000_0100,
  parameter int                INSTR_BYTES = 4,
  parameter int                RAS_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         halt_req,
  input  logic                         redirect_valid,
  input  logic [WIDTH-1:0]             redirect_target,
  input  logic                         trap_valid,
  input  logic                         ras_push,
  input  logic [WIDTH-1:0]             ras_push_addr,
  input  logic                         ras_pop,
  input  logic                         fetch_ready,
  output logic                         fetch_valid,
  output logic [WIDTH-1:0]             pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         misalign_err
);

  localparam int                PTR_W      = $clog2(RAS_DEPTH);
  localparam int                CNT_W      = PTR_W + 1;
  localparam logic [WIDTH-1:0]  ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);
  localparam logic [WIDTH-1:0]  STEP       = WIDTH'(INSTR_BYTES);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALTED
  } state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   pc_reg;
  logic               fetch_valid_reg;
  logic               misalign_reg;
  logic [CNT_W-1:0]   ras_count_reg;
  logic [PTR_W-1:0]   ras_top_reg;
  logic [WIDTH-1:0]   ras_mem [RAS_DEPTH];

  logic               active;
  logic               in_run;
  logic               fire;
  logic               take_trap;
  logic               take_redir;
  logic               take_halt;
  logic               take_pop;
  logic               take_seq;
  logic               do_push;
  logic [WIDTH-1:0]   redir_aligned;
  logic               redir_misaligned;
  logic [PTR_W-1:0]   ras_top_inc;
  logic [PTR_W-1:0]   ras_top_dec;
  logic [WIDTH-1:0]   ras_top_data;

  // Selection is a strict priority chain; BOOT swallows every request.
  always_comb begin
    active           = (state_reg != ST_BOOT);
    in_run           = (state_reg == ST_RUN);
    fire             = fetch_valid_reg & fetch_ready & ~stall;
    take_trap        = active & trap_valid;
    take_redir       = active & ~trap_valid & redirect_valid;
    take_halt        = active & ~trap_valid & ~redirect_valid & halt_req;
    take_pop         = in_run & ~trap_valid & ~redirect_valid & ~halt_req &
                       fire & ras_pop & (ras_count_reg != '0);
    take_seq         = in_run & ~trap_valid & ~redirect_valid & ~halt_req &
                       fire & ~take_pop;
    do_push          = active & ras_push;
    redir_aligned    = redirect_target & ~ALIGN_MASK;
    redir_misaligned = |(redirect_target & ALIGN_MASK);
    ras_top_inc      = ras_top_reg + PTR_W'(1);
    ras_top_dec      = ras_top_reg - PTR_W'(1);
    ras_top_data     = ras_mem[ras_top_reg];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_BOOT;
      pc_reg          <= RESET_ADDR;
      fetch_valid_reg <= 1'b0;
      misalign_reg    <= 1'b0;
    end else begin
      misalign_reg <= take_redir & redir_misaligned;
      case (state_reg)
        ST_BOOT: begin
          state_reg       <= ST_RUN;
          fetch_valid_reg <= 1'b1;
        end
        default: begin
          if (take_trap) begin
            pc_reg          <= TRAP_VECTOR;
            state_reg       <= ST_RUN;
            fetch_valid_reg <= 1'b1;
          end else if (take_redir) begin
            pc_reg          <= redir_aligned;
            state_reg       <= ST_RUN;
            fetch_valid_reg <= 1'b1;
          end else if (take_halt) begin
            state_reg       <= ST_HALTED;
            fetch_valid_reg <= 1'b0;
          end else if (take_pop) begin
            pc_reg <= ras_top_data;
          end else if (take_seq) begin
            pc_reg <= pc_reg + STEP;
          end
        end
      endcase
    end
  end

  // Simultaneous push and consumed pop leave pointer and count untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_top_reg   <= '0;
      ras_count_reg <= '0;
    end else if (do_push && !take_pop) begin
      ras_top_reg   <= ras_top_inc;
      ras_count_reg <= (ras_count_reg == CNT_FULL) ? CNT_FULL : ras_count_reg + CNT_W'(1);
    end else if (take_pop && !do_push) begin
      ras_top_reg   <= ras_top_dec;
      ras_count_reg <= ras_count_reg - CNT_W'(1);
    end
  end

  // Storage carries no reset; a push into a full stack lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (do_push) begin
      if (take_pop) begin
        ras_mem[ras_top_reg] <= ras_push_addr;
      end else begin
        ras_mem[ras_top_inc] <= ras_push_addr;
      end
    end
  end

  assign fetch_valid  = fetch_valid_reg;
  assign pc           = pc_reg;
  assign ras_count    = ras_count_reg;
  assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed, table-driven bench for pc_fetch_ctrl with default parameters.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        halt_req;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic        ras_push;
  logic [31:0] ras_push_addr;
  logic        ras_pop;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc;
  logic [2:0]  ras_count;
  logic        misalign_err;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .trap_valid     (trap_valid),
    .ras_push       (ras_push),
    .ras_push_addr  (ras_push_addr),
    .ras_pop        (ras_pop),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .pc             (pc),
    .ras_count      (ras_count),
    .misalign_err   (misalign_err)
  );

  typedef struct {
    int          reps;
    logic        rdy, stl, hlt, trp, rdv;
    logic [31:0] tgt;
    logic        psh;
    logic [31:0] pad;
    logic        pop;
    logic        efv;
    logic [31:0] epc;
    logic [2:0]  ecnt;
    logic        emis;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input int reps, input int rdy, input int stl, input int hlt,
                     input int trp, input int rdv, input logic [31:0] tgt,
                     input int psh, input logic [31:0] pad, input int pop,
                     input int efv, input logic [31:0] epc, input int ecnt, input int emis);
    vec_t v;
    v.reps = reps;  v.rdy = rdy[0]; v.stl = stl[0]; v.hlt = hlt[0];
    v.trp  = trp[0]; v.rdv = rdv[0]; v.tgt = tgt;    v.psh = psh[0];
    v.pad  = pad;   v.pop = pop[0]; v.efv = efv[0]; v.epc = epc;
    v.ecnt = 3'(ecnt); v.emis = emis[0];
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic efv, input logic [31:0] epc,
                         input logic [2:0] ecnt, input logic emis);
    chk({tag, ".fetch_valid"},  idx, 32'(fetch_valid),  32'(efv));
    chk({tag, ".pc"},           idx, pc,                epc);
    chk({tag, ".ras_count"},    idx, 32'(ras_count),    32'(ecnt));
    chk({tag, ".misalign_err"}, idx, 32'(misalign_err), 32'(emis));
  endtask

  task automatic drive(input vec_t v);
    fetch_ready = v.rdy; stall = v.stl; halt_req = v.hlt; trap_valid = v.trp;
    redirect_valid = v.rdv; redirect_target = v.tgt; ras_push = v.psh;
    ras_push_addr = v.pad; ras_pop = v.pop;
  endtask

  task automatic idle();
    fetch_ready = 1'b0; stall = 1'b0; halt_req = 1'b0; trap_valid = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0; ras_push = 1'b0;
    ras_push_addr = '0; ras_pop = 1'b0;
  endtask

  initial begin
    //   reps rdy stl hlt trp rdv tgt          psh pad     pop  efv epc          cnt mis
    add(1,   1,  0,  0,  0,  0,  0,           0,  0,      0,   1,  'h0,          0,  0);
    add(1,   1,  0,  0,  0,  0,  0,           0,  0,      0,   1,  'h4,          0,  0);
    add(1,   1,  0,  0,  0,  0,  0,           0,  0,      0,   1,  'h8,          0,  0);
    add(1,   1,  0,  0,  0,  0,  0,           0,  0,      0,   1,  'hC,          0,  0);
    add(1,   1,  0,  0,  0,  0,  0,           0,  0,      0,   1,  'h10,         0,  0);
    add(3,   0,  0,  0,  0,  0,  0,           0,  0,      0,   1,  'h10,         0,  0);
    add(2,   1,  1,  0,  0,  0,  0,           0,  0,      0,   1,  'h10,         0,  0);
    add(1,   1,  0,  0,  0,  0,  0,           0,  0,      0,   1,  'h14,         0,  0);
    add(1,   1,  1,  0,  1,  1,  'h200,       0,  0,      0,   1,  'h100,        0,  0);
    add(1,   1,  0,  0,  0,  1,  'h202,       0,  0,      0,   1,  'h200,        0,  1);
    add(1,   0,  0,  0,  0,  0,  0,           0,  0,      0,   1,  'h200,        0,  0);
    add(1,   0,  0,  0,  0,  0,  0,           1,  'h40,   0,   1,  'h200,        1,  0);
    add(1,   0,  0,  0,  0,  0,  0,           1,  'h44,   0,   1,  'h200,        2,  0);
    add(1,   0,  0,  0,  0,  0,  0,           1,  'h48,   0,   1,  'h200,        3,  0);
    add(1,   0,  0,  0,  0,  0,  0,           1,  'h4C,   0,   1,  'h200,        4,  0);
    add(1,   0,  0,  0,  0,  0,  0,           1,  'h50,   0,   1,  'h200,        4,  0);
    add(1,   1,  0,  0,  0,  0,  0,           0,  0,      1,   1,  'h50,         3,  0);
    add(1,   1,  0,  0,  0,  0,  0,           0,  0,      1,   1,  'h4C,         2,  0);
    add(1,   1,  0,  0,  0,  0,  0,           0,  0,      1,   1,  'h48,         1,  0);
    add(1,   1,  0,  0,  0,  0,  0,           0,  0,      1,   1,  'h44,         0,  0);
    add(1,   1,  0,  0,  0,  0,  0,           0,  0,      1,   1,  'h48,         0,  0);
    add(1,   0,  0,  0,  0,  0,  0,           1,  'h60,   0,   1,  'h48,         1,  0);
    add(1,   0,  0,  0,  0,  0,  0,           0,  0,      1,   1,  'h48,         1,  0);
    add(1,   1,  1,  0,  0,  0,  0,           0,  0,      1,   1,  'h48,         1,  0);
    add(1,   1,  0,  0,  0,  0,  0,           1,  'h70,   1,   1,  'h60,         1,  0);
    add(1,   1,  0,  0,  0,  0,  0,           0,  0,      1,   1,  'h70,         0,  0);
    add(1,   1,  0,  0,  0,  1,  'h30,        0,  0,      0,   1,  'h30,         0,  0);
    add(1,   1,  0,  1,  0,  0,  0,           0,  0,      0,   0,  'h30,         0,  0);
    add(10,  1,  0,  0,  0,  0,  0,           0,  0,      0,   0,  'h30,         0,  0);
    add(1,   1,  0,  0,  0,  0,  0,           1,  'h90,   0,   0,  'h30,         1,  0);
    add(1,   1,  0,  0,  0,  0,  0,           0,  0,      1,   0,  'h30,         1,  0);
    add(1,   1,  0,  0,  0,  1,  'h80,        0,  0,      0,   1,  'h80,         1,  0);
    add(1,   1,  0,  0,  0,  0,  0,           0,  0,      0,   1,  'h84,         1,  0);
    add(1,   1,  0,  1,  0,  0,  0,           0,  0,      0,   0,  'h84,         1,  0);
    add(1,   1,  0,  0,  1,  0,  0,           0,  0,      0,   1,  'h100,        1,  0);
    add(1,   0,  1,  0,  0,  1,  'h83,        0,  0,      0,   1,  'h80,         1,  1);
    add(1,   1,  0,  0,  0,  1,  'hFFFF_FFFC, 0,  0,      0,   1,  'hFFFF_FFFC,  1,  0);
    add(1,   1,  0,  0,  0,  0,  0,           0,  0,      0,   1,  'h0,          1,  0);
    add(1,   1,  0,  0,  0,  0,  0,           0,  0,      1,   1,  'h90,         0,  0);
    add(1,   1,  0,  1,  0,  1,  'h10,        0,  0,      0,   1,  'h10,         0,  0);

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 1'b0, 32'h0, 3'd0, 1'b0);
    $display("[TB] reset held: fv=%0b pc=%h cnt=%0d", fetch_valid, pc, ras_count);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        drive(vecs[i]);
        @(posedge clk);
        #1;
        chk_all("vec", i, vecs[i].efv, vecs[i].epc, vecs[i].ecnt, vecs[i].emis);
        $display("[TB] vec %0d.%0d: fv=%0b pc=%h cnt=%0d mis=%0b",
                 i, r, fetch_valid, pc, ras_count, misalign_err);
      end
    end

    // Asynchronous reset in the middle of a fetch burst.
    idle();
    fetch_ready = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 1'b0, 32'h0, 3'd0, 1'b0);
    $display("[TB] async reset: fv=%0b pc=%h cnt=%0d", fetch_valid, pc, ras_count);

    // Requests presented during BOOT must be ignored.
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    trap_valid      = 1'b1;
    ras_push        = 1'b1;
    ras_push_addr   = 32'h44;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("boot_ignore", 0, 1'b1, 32'h0, 3'd0, 1'b0);
    $display("[TB] boot edge: fv=%0b pc=%h cnt=%0d", fetch_valid, pc, ras_count);

    idle();
    fetch_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_all("after_boot", 0, 1'b1, 32'h4, 3'd0, 1'b0);
    $display("[TB] post-boot fetch: fv=%0b pc=%h cnt=%0d", fetch_valid, pc, ras_count);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
